alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 104 ++++++++++
 tb/tb_alu_issue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: one-entry operand stage feeding an external ALU,
// followed by a 2-entry response FIFO with valid/ready on both ends.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_op,
  input  logic [3:0]  req_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err
);

  logic        s1_v;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic [3:0]  s1_op;
  logic [3:0]  s1_tag;
  logic        s1_err;

  logic [1:0][31:0] f_res;
  logic [1:0][3:0]  f_tag;
  logic [1:0]       f_err;
  logic             wptr;
  logic             rptr;
  logic [1:0]       cnt;

  logic pop;
  logic adv;
  logic acc;

  assign pop       = rsp_valid & rsp_ready;
  assign adv       = s1_v & ((cnt != 2'd2) | pop);
  assign req_ready = ~s1_v | adv;
  assign acc       = req_valid & req_ready;

  // Opcodes A..F are flagged but still executed.
  assign s1_err = s1_op[3] & (s1_op[2:0] >= 3'd2);

  assign alu_a  = s1_v ? s1_a  : 32'd0;
  assign alu_b  = s1_v ? s1_b  : 32'd0;
  assign alu_op = s1_v ? s1_op : 4'd0;

  assign rsp_valid = (cnt != 2'd0);
  assign rsp_res   = rsp_valid ? f_res[rptr] : 32'd0;
  assign rsp_tag   = rsp_valid ? f_tag[rptr] : 4'd0;
  assign rsp_err   = rsp_valid & f_err[rptr];

  // Operand stage: reload on accept, empty when it drains with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_a   <= 32'd0;
      s1_b   <= 32'd0;
      s1_op  <= 4'd0;
      s1_tag <= 4'd0;
    end else if (acc) begin
      s1_v   <= 1'b1;
      s1_a   <= req_a;
      s1_b   <= req_b;
      s1_op  <= req_op;
      s1_tag <= req_tag;
    end else if (adv) begin
      s1_v   <= 1'b0;
    end
  end

  // Response FIFO: captures the ALU result as the operand stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_res <= '0;
      f_tag <= '0;
      f_err <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      if (adv) begin
        f_res[wptr] <= alu_res;
        f_tag[wptr] <= s1_tag;
        f_err[wptr] <= s1_err;
        wptr        <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      unique case ({adv, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed stimulus with an in-order response model
// (capacity three, one-edge minimum latency) checked every cycle.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [3:0]  req_op = 4'd0;
  logic [3:0]  req_tag = 4'd0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_tag   (req_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err)
  );

  // External ALU; undefined opcodes return ~(a+b).
  function automatic logic [31:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [3:0]  op);
    logic [32:0] s;
    logic [31:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = ~s[31:0];
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a >> b[4:0];
      4'd6: r = $unsigned($signed(a) >>> b[4:0]);
      4'd7: r = a << b[4:0];
      4'd8: r = {31'd0, s[32]};
      4'd9: r = {31'd0, a < b};
      default: r = ~s[31:0];
    endcase
    return r;
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
    int          acc;
  } item_t;

  item_t      q[$];
  int         cyc = 0;
  int         pop_cyc[$];
  int         acc_cyc[$];
  logic [3:0] seen[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Oldest item is visible once it has sat through at least one edge.
  function automatic bit exp_valid();
    return q.size() > 0 && q[0].acc <= cyc - 2;
  endfunction

  // At most three requests in flight; a full block frees a slot on pop.
  function automatic bit exp_ready();
    return q.size() < 3 || rsp_ready;
  endfunction

  // Model update at each edge; reset empties everything.
  always @(posedge clk or negedge rst_n) begin
    bit    p;
    bit    a;
    item_t it;
    if (!rst_n) begin
      q.delete();
    end else begin
      p = exp_valid() && rsp_ready;
      a = req_valid && exp_ready();
      if (p) begin
        seen.push_back(q[0].tag);
        pop_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (a) begin
        it.res = alu_f(req_a, req_b, req_op);
        it.tag = req_tag;
        it.err = req_op[3] && (req_op[2:0] >= 3'd2);
        it.acc = cyc;
        q.push_back(it);
        acc_cyc.push_back(cyc);
      end
      cyc++;
    end
  end

  // Compare DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid()));
      chk("req_ready", 32'(req_ready), 32'(exp_ready()));
      if (exp_valid()) begin
        chk("rsp_res", rsp_res, q[0].res);
        chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
        chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] tag);
    int n;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_tag   = tag;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [3:0] tag,
                        input logic [31:0] er, input logic ee);
    send(a, b, op, tag);
    @(negedge clk);
    chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_e1_valid", 32'(rsp_valid), 32'd1);
    chk("lit_res", rsp_res, er);
    chk("lit_tag", 32'(rsp_tag), 32'(tag));
    chk("lit_err", 32'(rsp_err), 32'(ee));
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    single(32'd3, 32'd5, 4'd1, 4'd2, 32'hFFFF_FFFE, 1'b0);
    single(32'd3, 32'd5, 4'd9, 4'd3, 32'd1, 1'b0);
    single(32'hFFFF_FFFF, 32'd1, 4'd8, 4'd4, 32'd1, 1'b0);
    single(32'h8000_0000, 32'd4, 4'd6, 4'd5, 32'hF800_0000, 1'b0);
    single(32'd7, 32'd1, 4'hC, 4'd6, 32'hFFFF_FFF7, 1'b1);
    single(32'd5, 32'd3, 4'd7, 4'd7, 32'h28, 1'b0);
    single(32'hF0, 32'hFF, 4'd4, 4'd8, 32'h0F, 1'b0);
    single(32'h8000_0000, 32'd4, 4'd5, 4'd9, 32'h0800_0000, 1'b0);

    // Backpressure: fill FIFO and operand stage, stall tag 4.
    rsp_ready = 1'b0;
    seen.delete();
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          send(32'(i * 16), 32'd1, 4'd0, 4'(i));
        end
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        chk("bp_head_tag", 32'(rsp_tag), 32'd1);
        chk("bp_s1_alu_a", alu_a, 32'd48);
        repeat (3) @(negedge clk);
        chk("bp_head_stable", 32'(rsp_tag), 32'd1);
        chk("bp_res_stable", rsp_res, 32'd17);
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #2;
    chk("bp_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < seen.size(); i++) begin
      chk("bp_order", 32'(seen[i]), 32'(i + 1));
    end

    // Streaming: 16 back-to-back requests.
    acc_cyc.delete();
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      send(32'(i * 3), 32'(i + 1), 4'(i % 10), 4'(i));
    end
    repeat (6) @(posedge clk);
    #2;
    chk("st_acc_count", 32'(acc_cyc.size()), 32'd16);
    chk("st_pop_count", 32'(pop_cyc.size()), 32'd16);
    if (acc_cyc.size() == 16 && pop_cyc.size() == 16) begin
      chk("st_acc_span", 32'(acc_cyc[15] - acc_cyc[0]), 32'd15);
      chk("st_pop_span", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);
    end

    // Reset with FIFO full and operand stage occupied.
    rsp_ready = 1'b0;
    send(32'd1, 32'd1, 4'd0, 4'd9);
    send(32'd2, 32'd1, 4'd0, 4'd10);
    send(32'd3, 32'd1, 4'd0, 4'd11);
    #1;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    @(posedge clk);
    #2;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #2;
    single(32'd2, 32'd2, 4'd0, 4'd1, 32'd4, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
